// File: rtl/reset_pkg.sv
// Shared encodings for the board reset sequencer: FSM states, reset-cause codes
// and the saturating event-counter helper.
package reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_BTN_HELD = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer_debouncer.sv
// Push-button front end: metastability synchronizer followed by a debouncer
// that flips its accepted level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q, level_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sample;
    logic                   flip;

    assign sample = sync_q[SYNC_STAGES-1];
    // The flip is decided from registered state, so the pulses are clean in clk.
    assign flip   = (sample != level_q) && (cnt_q == CNT_LAST);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) level_d = ~level_q;
            else                   cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_async_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = flip & ~level_q;
    assign release_o = flip &  level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset generator: merges board, button and software resets, stretches
// each one by HOLD_CYCLES and tracks the cause and number of resets.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_i,
    input  logic       sw_rst_req_i,
    output logic       soc_rst_n_o,
    output logic       rst_active_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] rst_count_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   rst_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_ok = rst_sync_q[SYNC_STAGES-1];

    logic btn_level, btn_press, btn_release;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_async_i(button_i),
        .level_o    (btn_level),
        .press_o    (btn_press),
        .release_o  (btn_release)
    );

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    cause_q, cause_d;
    logic [7:0]    count_q, count_d;
    logic          soc_q, active_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            ST_HOLD: begin
                // Hold time only starts once the board reset has been synchronously released.
                if (!rst_ok)                  hold_d  = '0;
                else if (btn_level)           state_d = ST_BTN_HELD;
                else if (hold_q == HOLD_LAST) state_d = ST_RUN;
                else                          hold_d  = hold_q + HW'(1);
            end
            ST_RUN: begin
                if (btn_press) begin
                    state_d = ST_BTN_HELD;
                    cause_d = CAUSE_BTN;
                    count_d = sat_inc8(count_q);
                end else if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    cause_d = CAUSE_SW;
                    count_d = sat_inc8(count_q);
                end
            end
            ST_BTN_HELD: begin
                if (btn_release) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HOLD;
            hold_q   <= '0;
            cause_q  <= CAUSE_POR;
            count_q  <= '0;
            soc_q    <= 1'b0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            soc_q    <= (state_d == ST_RUN);
            active_q <= (state_d != ST_RUN);
        end
    end

    assign soc_rst_n_o  = soc_q;
    assign rst_active_o = active_q;
    assign rst_cause_o  = cause_q;
    assign rst_count_o  = count_q;

endmodule
